// File: rtl/load_store_unit.sv
// Load/store sequencer between the processor datapath and an 8-bit data memory.
// Each accepted request runs IDLE -> READ/WRITE -> DONE -> IDLE. Out-of-range
// requests skip the memory phase and go straight to DONE with err.
// A wrapping count of completed, non-rejected accesses is kept in acc_count.
module load_store_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LIMIT  = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [7:0]        acc_count,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] escreveDado,
    input  logic [DATA_W-1:0] leDado
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One extra bit so LIMIT equal to the largest address is representable.
    localparam logic [ADDR_W:0] LIMIT_X = (ADDR_W + 1)'(LIMIT);

    state_t state;
    state_t state_next;
    logic   rejected;
    logic   out_of_range;

    assign out_of_range = {1'b0, addr} > LIMIT_X;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; requests are only looked at while idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (out_of_range) begin
                        state_next = DONE;
                    end else if (we) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = DONE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, load result and access counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            endereco    <= '0;
            escreveDado <= '0;
            rejected    <= 1'b0;
            rdata       <= '0;
            acc_count   <= '0;
        end else begin
            if (state == IDLE && req) begin
                endereco    <= addr;
                escreveDado <= wdata;
                rejected    <= out_of_range;
            end
            if (state == READ) begin
                rdata <= leDado;
            end
            // Counted on entry to DONE so the new value is visible with done.
            if (state == READ || state == WRITE) begin
                acc_count <= acc_count + 8'd1;
            end
        end
    end

    // Every output is a decode of registered state, never of the request inputs.
    assign ready    = (state == IDLE);
    assign done     = (state == DONE);
    assign err      = (state == DONE) && rejected;
    assign memRead  = (state == READ);
    assign memWrite = (state == WRITE);

endmodule
